// File: rtl/gpio_port_bank_pkg.sv
// Shared definitions for the GPIO port bank.
// Holds the register codes used on addr_bus nibbles and the default bus width.
package gpio_port_bank_pkg;

  localparam int unsigned GPIO_DEFAULT_DATA_WIDTH = 8;

  // Register codes: addr_bus[7:4] selects the read register,
  // addr_bus[3:0] selects the write register. REG_NONE means no access.
  typedef enum logic [3:0] {
    REG_NONE = 4'h0,
    REG_SEL  = 4'h8,
    REG_DAT  = 4'h9,
    REG_DIR  = 4'hA,
    REG_IEN  = 4'hB,
    REG_IFL  = 4'hC
  } reg_code_e;

endpackage

// File: rtl/gpio_port_channel.sv
// One GPIO port: input synchroniser, output latch, direction register and,
// when GPIO_EDGE_IRQ_EN is defined, previous-sample register, interrupt
// enable and interrupt flag storage.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   pin_in              asynchronous pad inputs of this port
//   wdata               bus write data
//   wr_dat/dir/ien/ifl  write strobes for this port's registers
//   latch, dir          output latch and per-bit output enable
//   rd_dat              merged read value (latch where driving, sync input otherwise)
//   rd_ien, rd_ifl      enable/flag read values (0 when the feature is absent)
//   irq_term            |(IFL & IEN) of this port (0 when the feature is absent)
module gpio_port_channel #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pin_in,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wr_dat,
  input  logic                  wr_dir,
  input  logic                  wr_ien,
  input  logic                  wr_ifl,
  output logic [DATA_WIDTH-1:0] latch,
  output logic [DATA_WIDTH-1:0] dir,
  output logic [DATA_WIDTH-1:0] rd_dat,
  output logic [DATA_WIDTH-1:0] rd_ien,
  output logic [DATA_WIDTH-1:0] rd_ifl,
  output logic                  irq_term
);

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      latch <= '0;
      dir   <= '0;
    end else begin
      if (wr_dat) latch <= wdata;
      if (wr_dir) dir   <= wdata;
    end
  end

  assign rd_dat = (dir & latch) | (~dir & sync_last);

`ifdef GPIO_EDGE_IRQ_EN
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] ien_q;
  logic [DATA_WIDTH-1:0] ifl_q;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] clr_mask;

  assign rise     = sync_last & ~prev_q;
  assign clr_mask = wr_ifl ? wdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= '0;
      ien_q  <= '0;
      ifl_q  <= '0;
    end else begin
      prev_q <= sync_last;
      if (wr_ien) ien_q <= wdata;
      // Clear is applied before set so a coincident edge keeps its flag.
      ifl_q <= (ifl_q & ~clr_mask) | (rise & ien_q);
    end
  end

  assign rd_ien   = ien_q;
  assign rd_ifl   = ifl_q;
  assign irq_term = |(ifl_q & ien_q);
`else
  logic unused_wr;
  assign unused_wr = wr_ien ^ wr_ifl;
  assign rd_ien    = '0;
  assign rd_ifl    = '0;
  assign irq_term  = 1'b0;
`endif

endmodule

// File: rtl/gpio_port_bank.sv
// Memory-mapped bank of NPORT bidirectional GPIO ports with indirect access:
// write SEL to pick a port, then access its DAT/DIR/IEN/IFL registers.
// Optional rising-edge interrupts are built when GPIO_EDGE_IRQ_EN is defined;
// otherwise IEN/IFL read 0, ignore writes and irq is tied 0.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   addr_bus       [7:4] read-register code, [3:0] write-register code
//   data_bus_in    write data
//   data_bus_out   combinational read data for addr_bus[7:4]
//   pin_in         asynchronous pad inputs, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   pin_out        output latches
//   pin_oe         per-bit output enable (1 = drive)
//   irq            registered OR of all enabled pending flags
module gpio_port_bank
  import gpio_port_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = GPIO_DEFAULT_DATA_WIDTH,
  parameter int unsigned NPORT       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       addr_bus,
  input  logic [DATA_WIDTH-1:0]       data_bus_in,
  output logic [DATA_WIDTH-1:0]       data_bus_out,
  input  logic [NPORT*DATA_WIDTH-1:0] pin_in,
  output logic [NPORT*DATA_WIDTH-1:0] pin_out,
  output logic [NPORT*DATA_WIDTH-1:0] pin_oe,
  output logic                        irq
);

  logic [3:0]            wr_code;
  logic [3:0]            rd_code;
  logic [DATA_WIDTH-1:0] sel_q;

  logic [DATA_WIDTH-1:0] dat_rd [NPORT];
  logic [DATA_WIDTH-1:0] dir_rd [NPORT];
  logic [DATA_WIDTH-1:0] ien_rd [NPORT];
  logic [DATA_WIDTH-1:0] ifl_rd [NPORT];
  logic [NPORT-1:0]      irq_terms;

  assign wr_code = addr_bus[3:0];
  assign rd_code = addr_bus[7:4];

  always_ff @(posedge clk) begin
    if (!rst_n)               sel_q <= '0;
    else if (wr_code == REG_SEL) sel_q <= data_bus_in;
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic hit;
    assign hit = (sel_q == DATA_WIDTH'(p));

    gpio_port_channel #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_channel (
      .clk      (clk),
      .rst_n    (rst_n),
      .pin_in   (pin_in[p*DATA_WIDTH +: DATA_WIDTH]),
      .wdata    (data_bus_in),
      .wr_dat   (hit && (wr_code == REG_DAT)),
      .wr_dir   (hit && (wr_code == REG_DIR)),
      .wr_ien   (hit && (wr_code == REG_IEN)),
      .wr_ifl   (hit && (wr_code == REG_IFL)),
      .latch    (pin_out[p*DATA_WIDTH +: DATA_WIDTH]),
      .dir      (pin_oe[p*DATA_WIDTH +: DATA_WIDTH]),
      .rd_dat   (dat_rd[p]),
      .rd_ien   (ien_rd[p]),
      .rd_ifl   (ifl_rd[p]),
      .irq_term (irq_terms[p])
    );

    assign dir_rd[p] = pin_oe[p*DATA_WIDTH +: DATA_WIDTH];
  end

  // An out-of-range SEL matches no port, so the per-port values stay 0.
  always_comb begin
    logic [DATA_WIDTH-1:0] sel_dat;
    logic [DATA_WIDTH-1:0] sel_dir;
    logic [DATA_WIDTH-1:0] sel_ien;
    logic [DATA_WIDTH-1:0] sel_ifl;
    sel_dat = '0;
    sel_dir = '0;
    sel_ien = '0;
    sel_ifl = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (sel_q == DATA_WIDTH'(p)) begin
        sel_dat = dat_rd[p];
        sel_dir = dir_rd[p];
        sel_ien = ien_rd[p];
        sel_ifl = ifl_rd[p];
      end
    end
    data_bus_out = '0;
    case (rd_code)
      REG_SEL: data_bus_out = sel_q;
      REG_DAT: data_bus_out = sel_dat;
      REG_DIR: data_bus_out = sel_dir;
      REG_IEN: data_bus_out = sel_ien;
      REG_IFL: data_bus_out = sel_ifl;
      default: data_bus_out = '0;
    endcase
  end

`ifdef GPIO_EDGE_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |irq_terms;
  end
`else
  logic unused_irq_terms;
  assign unused_irq_terms = |irq_terms;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_port_bank.sv
// Directed testbench for gpio_port_bank with a scoreboard queue of expected
// values. Interrupt expectations follow GPIO_EDGE_IRQ_EN: with it undefined,
// IFL reads and irq are expected to stay 0.
module tb_gpio_port_bank;

  localparam int unsigned DW = 8;
  localparam int unsigned NP = 4;
  localparam int unsigned SS = 2;
`ifdef GPIO_EDGE_IRQ_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  localparam logic [3:0] C_SEL = 4'h8;
  localparam logic [3:0] C_DAT = 4'h9;
  localparam logic [3:0] C_DIR = 4'hA;
  localparam logic [3:0] C_IEN = 4'hB;
  localparam logic [3:0] C_IFL = 4'hC;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DW-1:0]     addr_bus;
  logic [DW-1:0]     data_bus_in;
  logic [DW-1:0]     data_bus_out;
  logic [NP*DW-1:0]  pin_in;
  logic [NP*DW-1:0]  pin_out;
  logic [NP*DW-1:0]  pin_oe;
  logic              irq;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  gpio_port_bank #(
    .DATA_WIDTH  (DW),
    .NPORT       (NP),
    .SYNC_STAGES (SS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr_bus     (addr_bus),
    .data_bus_in  (data_bus_in),
    .data_bus_out (data_bus_out),
    .pin_in       (pin_in),
    .pin_out      (pin_out),
    .pin_oe       (pin_oe),
    .irq          (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
    end else begin
      exp_v = sb.pop_front();
      assert (obs === exp_v) else begin
        n_errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic wr(input logic [3:0] code, input logic [DW-1:0] d);
    addr_bus    = {4'h0, code};
    data_bus_in = d;
    tick();
    addr_bus    = '0;
    data_bus_in = '0;
  endtask

  task automatic rd(input logic [3:0] code, output logic [DW-1:0] v);
    addr_bus = {code, 4'h0};
    #1;
    v = data_bus_out;
    addr_bus = '0;
  endtask

  task automatic set_pin(input int unsigned port, input logic [DW-1:0] v);
    pin_in[port*DW +: DW] = v;
  endtask

  initial begin
    logic [DW-1:0] v;
    rst_n       = 1'b0;
    addr_bus    = '0;
    data_bus_in = '0;
    pin_in      = '0;

    // Reset with toggling pins
    for (int i = 0; i < 2; i++) begin
      pin_in = $urandom();
      tick();
    end
    expect_val(32'h0); check("rst_pin_oe", pin_oe);
    expect_val(32'h0); check("rst_pin_out", pin_out);
    expect_val(32'h0); check("rst_irq", {31'h0, irq});
    rd(C_SEL, v); expect_val(32'h0); check("rst_sel", {24'h0, v});
    rd(4'h0, v);  expect_val(32'h0); check("rst_noacc", {24'h0, v});
    pin_in = '0;
    rst_n  = 1'b1;
    repeat (3) tick();

    // Output path on port 2
    wr(C_SEL, 8'd2);
    wr(C_DIR, 8'hF0);
    wr(C_DAT, 8'hA5);
    expect_val(32'h00F0_0000); check("oe_port2", pin_oe);
    expect_val(32'h00A5_0000); check("out_port2", pin_out);
    set_pin(2, 8'h0C);
    repeat (2) tick();
    rd(C_DAT, v); expect_val(32'hAC); check("dat_merge", {24'h0, v});
    rd(C_DIR, v); expect_val(32'hF0); check("dir_read", {24'h0, v});

    // Read and write of DAT in the same cycle: read sees the old value
    addr_bus = {C_DAT, C_DAT};
    data_bus_in = 8'h5A;
    #1;
    expect_val(32'hAC); check("rw_same_old", {24'h0, data_bus_out});
    tick();
    addr_bus = '0;
    rd(C_DAT, v); expect_val(32'h5C); check("rw_same_new", {24'h0, v});

    // Sync latency on port 1
    wr(C_SEL, 8'd1);
    set_pin(1, 8'h01);
    rd(C_DAT, v); expect_val(32'h00); check("sync_pre", {24'h0, v});
    tick();
    rd(C_DAT, v); expect_val(32'h00); check("sync_k", {24'h0, v});
    tick();
    rd(C_DAT, v); expect_val(32'h01); check("sync_k1", {24'h0, v});

    // Interrupt on port 1 bit 0
    set_pin(1, 8'h00);
    repeat (3) tick();
    wr(C_IEN, 8'h01);
    set_pin(1, 8'h01);
    tick();
    tick();
    rd(C_IFL, v); expect_val(32'h00); check("ifl_k1", {24'h0, v});
    tick();
    rd(C_IFL, v); expect_val(EDGE ? 32'h01 : 32'h00); check("ifl_k2", {24'h0, v});
    expect_val(32'h0); check("irq_k2", {31'h0, irq});
    tick();
    expect_val({31'h0, EDGE}); check("irq_k3", {31'h0, irq});
    wr(C_IFL, 8'h01);
    rd(C_IFL, v); expect_val(32'h00); check("ifl_cleared", {24'h0, v});
    tick();
    expect_val(32'h0); check("irq_dropped", {31'h0, irq});

    // New edge coinciding with the clear: set wins
    set_pin(1, 8'h00);
    repeat (3) tick();
    set_pin(1, 8'h01);
    tick();
    tick();
    wr(C_IFL, 8'h01);
    rd(C_IFL, v); expect_val(EDGE ? 32'h01 : 32'h00); check("ifl_set_wins", {24'h0, v});

    // Clearing IEN masks irq but keeps the flag
    wr(C_IEN, 8'h00);
    rd(C_IFL, v); expect_val(EDGE ? 32'h01 : 32'h00); check("ifl_kept", {24'h0, v});
    tick();
    expect_val(32'h0); check("irq_masked", {31'h0, irq});

    // Out-of-range select
    wr(C_SEL, 8'(NP));
    wr(C_DAT, 8'hFF);
    expect_val(32'h005A_0000); check("oor_pin_out", pin_out);
    rd(C_DAT, v); expect_val(32'h00); check("oor_dat", {24'h0, v});
    rd(C_DIR, v); expect_val(32'h00); check("oor_dir", {24'h0, v});
    rd(C_SEL, v); expect_val(32'(NP)); check("oor_sel", {24'h0, v});

    // Reset mid-operation with a pending flag and pin held high
    wr(C_SEL, 8'd1);
    wr(C_IEN, 8'h01);
    tick();
    expect_val({31'h0, EDGE}); check("irq_pending", {31'h0, irq});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_val(32'h0); check("post_rst_irq", {31'h0, irq});
    wr(C_SEL, 8'd1);
    repeat (4) tick();
    rd(C_IFL, v); expect_val(32'h00); check("post_rst_ifl", {24'h0, v});
    rd(C_DAT, v); expect_val(32'h01); check("post_rst_dat", {24'h0, v});
    expect_val(32'h0); check("post_rst_irq2", {31'h0, irq});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpio_port_bank.md
# gpio_port_bank

Parametrised memory-mapped I/O port bank, the successor to the fixed three-port interface. It provides NPORT bidirectional ports of DATA_WIDTH bits, each with per-bit direction, an output latch, a multi-stage input synchroniser and optional rising-edge interrupt flags. It sits on the microcontroller's address/data bus and uses the same indirect scheme: select a port, then access its registers.

## Interface
- DATA_WIDTH, 8: width of the bus and of each port.
- NPORT, 4: number of ports; 1..16.
- SYNC_STAGES, 2: input synchroniser depth; minimum 2.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low; clock clk
- addr_bus  in  DATA_WIDTH  [7:4] read-register code, [3:0] write-register code; 4'h0 = no access
- data_bus_in  in  DATA_WIDTH  write data
- data_bus_out  out  DATA_WIDTH  read data, combinational from addr_bus[7:4]
- pin_in  in  NPORT*DATA_WIDTH  asynchronous pad inputs; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH]
- pin_out  out  NPORT*DATA_WIDTH  output latches
- pin_oe  out  NPORT*DATA_WIDTH  per-bit output enable (1 = drive)
- irq  out  1  OR of all enabled pending flags

## Operation
- Register codes: SEL 4'h8 (port select), DAT 4'h9, DIR 4'hA, IEN 4'hB, IFL 4'hC. All codes other than SEL act on port SEL.
- Write: on a posedge with addr_bus[3:0] = a code, the register takes data_bus_in. For IFL, this is write-1-to-clear.
- Read: data_bus_out returns the register named by addr_bus[7:4]. Unknown code or 4'h0 returns 0.
- DAT read returns the merged value per bit: DIR=1 returns the latch, DIR=0 returns the synchronised input.
- DAT write loads the output latch regardless of DIR.
- SEL >= NPORT: reads of DAT/DIR/IEN/IFL return 0 and writes to them are ignored. SEL itself always reads back its full value.
- pin_oe = DIR of each port; pin_out = latch.
- Edge detect: a bit rises when the last sync stage is 1 and the previous-sample register is 0. The flag bit is set if the matching IEN bit is 1.
- Simultaneous events:
  - Set and write-1-clear on the same cycle: set wins.
  - Read and write to the same register in one cycle: the read returns the old value.
  - Writing IEN bit to 0 does not clear an existing flag. It only masks the flag from irq.
- irq = |(IFL & IEN) across all ports, registered.

## Timing
- Reset values: SEL, all latches, DIR, IEN, IFL, sync and previous-sample registers = 0. Outputs at reset: pin_out=0, pin_oe=0 (all inputs), irq=0, data_bus_out=0 for code 4'h0.
- Writes are visible on outputs and reads one cycle after the write edge.
- Input latency: a pin_in change before edge k is visible in a DAT read after edge k+SYNC_STAGES-1. The flag sets at edge k+SYNC_STAGES, and irq asserts after edge k+SYNC_STAGES+1.
- Reset mid-operation clears pending flags and in-flight synchroniser contents. No edge is reported for a pin held high across reset release unless IEN was set beforehand, which reset prevents.

## Configuration
- GPIO_EDGE_IRQ_EN defined: edge detection, IEN, IFL and irq are implemented as above.
- Not defined: no previous-sample registers, IEN or IFL storage. IEN/IFL read 0, writes to them are ignored, and irq is tied 0.

## Structure
- Shared package / define header holds:
  - register codes SEL/DAT/DIR/IEN/IFL
  - code 4'h0 = no access
  - default DATA_WIDTH
- Sub-module gpio_port_channel, one instance per port. It contains:
  - synchroniser, previous-sample register, latch, DIR, IEN, IFL
  - merged read value and the per-port irq term
- Top-level logic: SEL register, address decode, read mux, irq OR-reduction and output register.

## Test plan
- Reset: assert rst_n=0 for 2 cycles with pins toggling -> pin_oe=0, pin_out=0, irq=0, SEL reads 0.
- Output path: SEL=2, DIR=8'hF0, DAT=8'hA5 -> port 2 pin_oe=F0 and pin_out=A5 one cycle later; DAT read with pin_in port2=8'h0C returns 8'hAC.
- Sync latency: port 1 pin_in 00->01 before edge k (DIR=0) -> DAT read is 00 through edge k and 01 after edge k+1 (SYNC_STAGES=2).
- Interrupt: IEN=8'h01 on port 1, pin bit0 rises at k -> IFL=01 after k+2, irq=1 after k+3; writing IFL=01 clears it and irq drops one cycle later. A new edge coinciding with the clear leaves IFL=01.
- Out-of-range: SEL=NPORT, write DAT=FF -> no pin_out change; DAT read returns 0; SEL read returns NPORT.
- Config off: build without GPIO_EDGE_IRQ_EN, repeat the interrupt test -> IFL reads 0 and irq stays 0.
